// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_unit
// Description : Instruction-fetch stage. Generates sequential PCs, issues reads
//               to a 1-cycle-latency synchronous instruction memory, buffers the
//               returned {pc, inst} pairs in a DEPTH-entry FIFO and hands them
//               to decode over valid/ready. A redirect flushes the queue, drops
//               the in-flight read and restarts fetch at the target.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int INST_W   = 8,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_next
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  localparam logic [ADDR_W-1:0] C_RESET_PC = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] C_PC_ONE   = ADDR_W'(1);
  localparam logic [OCC_W-1:0]  C_DEPTH    = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0]  C_PTR_ONE  = PTR_W'(1);

  // Fetch / request state
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_inflight;

  // FIFO state
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [INST_W-1:0] r_fifo_inst [DEPTH];
  logic [ADDR_W-1:0] r_fifo_pc   [DEPTH];

  logic [OCC_W-1:0]  w_occupancy;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_count_next;

  // Credit-based issue: an outstanding read reserves its FIFO slot, so the
  // response can always be written. Reset gating keeps the request low while
  // reset is asserted, before any clock edge arrives.
  always_comb begin
    w_occupancy = {1'b0, r_count} + OCC_W'(r_inflight);
    w_issue     = reset_n && !redirect_valid && (w_occupancy < C_DEPTH);
    w_push      = r_inflight && !redirect_valid;
    w_pop       = (r_count != '0) && out_ready && !redirect_valid;
  end

  // Occupancy after this edge's push and/or pop
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + C_CNT_ONE;
      2'b01:   w_count_next = r_count - C_CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  // Control state: redirect overrides every push, pop and issue at its edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc <= C_RESET_PC;
      r_req_pc   <= C_RESET_PC;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_count <= w_count_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      if (w_issue) begin
        r_inflight <= 1'b1;
        r_req_pc   <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + C_PC_ONE;
      end else begin
        r_inflight <= 1'b0;
      end
    end
  end

  // FIFO storage: contents are don't-care after reset, so no reset is applied
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_inst[r_wr_ptr] <= imem_rdata;
      r_fifo_pc[r_wr_ptr]   <= r_req_pc;
    end
  end

  // Output drive: memory port and FIFO head
  always_comb begin
    imem_req    = w_issue;
    imem_addr   = r_fetch_pc;
    out_valid   = (r_count != '0);
    out_inst    = r_fifo_inst[r_rd_ptr];
    out_pc      = r_fifo_pc[r_rd_ptr];
    out_pc_next = r_fifo_pc[r_rd_ptr] + C_PC_ONE;
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_prefetch_unit
// Description : Self-checking bench for fetch_prefetch_unit. A queue-based
//               reference model of the fetch/FIFO behaviour predicts every
//               output each cycle under directed and randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_unit;

  localparam int DEPTH = 4;

  logic       clock;
  logic       reset_n;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_inst;
  logic [7:0] out_pc;
  logic [7:0] out_pc_next;

  int checks;
  int failures;

  logic [7:0] imem [256];

  // Reference model state
  logic [7:0] m_q[$];
  logic [7:0] m_fetch;
  logic [7:0] m_req_pc;
  logic       m_inflight;

  fetch_prefetch_unit #(
    .ADDR_W  (8),
    .INST_W  (8),
    .DEPTH   (DEPTH),
    .RESET_PC(0)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .out_pc_next   (out_pc_next)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous instruction memory, one cycle read latency
  always @(posedge clock) begin
    if (imem_req) imem_rdata <= imem[imem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fetch    = 8'h00;
    m_req_pc   = 8'h00;
    m_inflight = 1'b0;
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs,
  // then advance the model across the coming rising edge.
  task automatic cycle(input logic rv, input logic [7:0] rpc, input logic rdy);
    logic       exp_req;
    logic [7:0] head;
    @(negedge clock);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
    exp_req = !rv && ((m_q.size() + int'(m_inflight)) < DEPTH);
    chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    chk("imem_addr", {24'd0, imem_addr}, {24'd0, m_fetch});
    chk("out_valid", {31'd0, out_valid}, {31'd0, (m_q.size() != 0)});
    if (m_q.size() != 0) begin
      head = m_q[0];
      chk("out_pc", {24'd0, out_pc}, {24'd0, head});
      chk("out_inst", {24'd0, out_inst}, {24'd0, imem[head]});
      chk("out_pc_next", {24'd0, out_pc_next}, {24'd0, 8'(head + 8'd1)});
    end
    if (rv) begin
      m_q.delete();
      m_inflight = 1'b0;
      m_fetch    = rpc;
    end else begin
      if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
      if (m_inflight) m_q.push_back(m_req_pc);
      if (exp_req) begin
        m_inflight = 1'b1;
        m_req_pc   = m_fetch;
        m_fetch    = m_fetch + 8'd1;
      end else begin
        m_inflight = 1'b0;
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) imem[i] = 8'(i) ^ 8'hA5;
    imem_rdata     = 8'h00;
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    out_ready      = 1'b0;
    model_reset();

    // Held in reset
    repeat (3) @(posedge clock);
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_imem_addr", {24'd0, imem_addr}, 32'd0);
    reset_n = 1'b1;

    // Sequential streaming with decode always ready
    for (int i = 0; i < 12; i++) cycle(1'b0, 8'h00, 1'b1);

    // Backpressure: queue fills and fetch stalls, then drains in order
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b0);
    chk("bp_full_size", m_q.size(), DEPTH);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);

    // Redirect while entries are queued
    cycle(1'b1, 8'h40, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1);

    // Wrap-around of the PC
    cycle(1'b1, 8'hFE, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);

    // Full queue with a pop coinciding with an arriving response
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, (i % 2) == 0);

    // Back-to-back redirects: only the last target is fetched
    cycle(1'b1, 8'h10, 1'b1);
    cycle(1'b1, 8'h20, 1'b1);
    cycle(1'b1, 8'h80, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);

    // Randomized ready / redirect traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 15) == 0), 8'($urandom), ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset between edges
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("arst_imem_addr", {24'd0, imem_addr}, 32'd0);
    model_reset();
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1);

    // More randomized traffic after the restart
    for (int i = 0; i < 200; i++) begin
      cycle(($urandom_range(0, 9) == 0), 8'($urandom), ($urandom_range(0, 1) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
